debug_scan_display: RTL
=======================

DEBUG_SCAN_DISPLAY -- requirements
Module: debug_scan_display

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of debug channels, 2..16.
REQ-002 SHALL have parameter DATA_W, default 16: channel width, a multiple of 4; DIGITS = DATA_W/4.
REQ-003 SHALL have parameter SCAN_PERIOD, default 50_000_000: clocks per channel in auto mode, at least 2.
REQ-004 SHALL have port CLOCK_50, input, 1: the only clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port ch_data, input, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-007 SHALL have port sel_sw, input, $clog2(NUM_CH): manual channel select.
REQ-008 SHALL have port auto_mode, input, 1: 1 = auto-scan, 0 = manual.
REQ-009 SHALL have port step, input, 1: single-cycle pulse (already debounced) that advances the channel in auto mode.
REQ-010 SHALL have port freeze, input, 1: level; while high, the display and the channel pointer hold.
REQ-011 SHALL have port ch_out, output, $clog2(NUM_CH): current channel pointer.
REQ-012 SHALL have port value_out, output, DATA_W: registered value of the displayed channel.
REQ-013 SHALL have port hex_out, output, DIGITS*7: registered 7-segment patterns, active-low.
- Digit d uses bits [d*7 +: 7], ordered a..g from MSB.
- Digit 0 is the least significant nibble.

Function
REQ-014 Manual mode: ch_out SHALL take sel_sw at each edge.
- sel_sw values >= NUM_CH SHALL clamp to NUM_CH-1.
REQ-015 Auto mode: a scan counter SHALL count 0..SCAN_PERIOD-1.
- At terminal count, ch_out SHALL advance by 1 and the counter SHALL return to 0.
REQ-016 Auto-mode wrap: ch_out = NUM_CH-1 SHALL advance to 0.
REQ-017 step high in auto mode SHALL advance ch_out by 1 and clear the scan counter in the same cycle.
REQ-018 step and terminal count in the same cycle SHALL advance ch_out by exactly 1.
REQ-019 step in manual mode SHALL be ignored.
REQ-020 Switching auto to manual SHALL load the clamped sel_sw at the next edge.
REQ-021 Switching manual to auto SHALL start scanning from the current ch_out with the counter at 0.
REQ-022 freeze high SHALL hold ch_out, the scan counter, value_out and hex_out; step SHALL be ignored while frozen.
REQ-023 freeze falling SHALL resume from the held state; the counter SHALL NOT be reset.
REQ-024 Output timing:
- value_out SHALL capture ch_data[ch_out] at each unfrozen edge.
- hex_out SHALL be registered in the same edge from the same mux output.
- Latency: ch_out change at edge k -> value_out/hex_out reflect it at edge k+1; ch_data change -> 1 cycle.
REQ-025 Hex encoding SHALL show 0-9 and A-F as in the existing board decoder (active-low, b/d lowercase).

Reset
REQ-026 Reset_n low at an edge SHALL clear all of the following:
- ch_out = 0, scan counter = 0, value_out = 0.
- hex_out = "0" on every digit: 7'b0000001 each, or blank per REQ-028.
REQ-027 Reset SHALL override freeze, step and mode in the same cycle; it SHALL abort a scan mid-period with no residual count.

Configuration
REQ-028 With macro DEBUG_SCAN_BLANK_EN defined: leading-zero digits SHALL be blanked (7'b1111111).
- Digit 0 SHALL never be blanked.
- Without the macro, all DIGITS digits SHALL always be shown.

Structure
REQ-029 Package debug_disp_pkg SHALL hold the following:
- typedef seg7_t (logic [0:6]).
- constants SEG_BLANK and SEG_ZERO.
- the 16-entry hex-to-segment table.
REQ-030 A single sub-module hex_seg7_decode (nibble in, seg7_t out, combinational) SHALL be instantiated DIGITS times; no other sub-modules.

Verification
REQ-031 Reset, then manual mode with sel_sw=3 and ch_data[3]=16'hBEEF:
- ch_out=3 after 1 edge.
- value_out=16'hBEEF and hex_out digits F,E,E,b after 2 edges.
REQ-032 SCAN_PERIOD=4, NUM_CH=3, auto mode from ch 0:
- ch_out sequence 0,1,2,0 with changes every 4 clocks.
- step pulsed on the terminal-count cycle -> single advance.
REQ-033 Freeze asserted mid-scan for 10 cycles while ch_data changes:
- ch_out, value_out and hex_out are unchanged during freeze.
- Scan resumes with the remaining count after freeze falls.
REQ-034 sel_sw=7 with NUM_CH=5 -> ch_out=4.
REQ-035 Reset_n low during auto scan with freeze high -> next edge shows all outputs at their reset values.
REQ-036 With DEBUG_SCAN_BLANK_EN, value 16'h0042 -> digits 3,2 blank, digits 1,0 show 4,2; value 0 -> only digit 0 shows "0".

Source files
------------

// File: rtl/debug_disp_pkg.sv
// -----------------------------------------------------------------------------
// debug_disp_pkg
// Shared types and constants for the debug scan display.
//   seg7_t     : one 7-segment digit, index 0 = segment a ... index 6 = segment g,
//                active-low (0 lights the segment).
//   SEG_BLANK  : all segments off.
//   SEG_ZERO   : the "0" glyph.
//   SEG_TABLE  : hex nibble -> glyph, same shapes as the board decoder
//                (b and d drawn lowercase so they differ from 8 and 0).
// -----------------------------------------------------------------------------
package debug_disp_pkg;

    typedef logic [0:6] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_ZERO  = 7'b0000001;

    localparam seg7_t SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/hex_seg7_decode.sv
// -----------------------------------------------------------------------------
// hex_seg7_decode
// Purely combinational nibble to 7-segment glyph lookup.
// Ports:
//   nibble : in,  4-bit hex value
//   seg    : out, active-low glyph (seg7_t, a..g)
// -----------------------------------------------------------------------------
module hex_seg7_decode
    import debug_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/debug_scan_display.sv
// -----------------------------------------------------------------------------
// debug_scan_display
// Selects one of NUM_CH debug channels, either from switches (manual) or by a
// free-running scan with optional single-step (auto), and shows the selected
// value on DIGITS active-low 7-segment digits.
//
// Parameters:
//   NUM_CH      : number of channels, 2..16
//   DATA_W      : channel width, multiple of 4 (DIGITS = DATA_W/4)
//   SCAN_PERIOD : clocks spent on each channel in auto mode, >= 2
// Ports:
//   CLOCK_50  : in,  the only clock, rising edge
//   Reset_n   : in,  synchronous active-low reset
//   ch_data   : in,  channel c at [c*DATA_W +: DATA_W]
//   sel_sw    : in,  manual channel select (clamped to NUM_CH-1)
//   auto_mode : in,  1 = auto scan, 0 = manual
//   step      : in,  one-cycle pulse, advances the channel in auto mode
//   freeze    : in,  level, holds pointer, scan counter and display
//   ch_out    : out, current channel pointer
//   value_out : out, registered value of the displayed channel
//   hex_out   : out, registered glyphs, digit d at [d*7 +: 7], digit 0 = LS nibble
//
// Build option: define DEBUG_SCAN_BLANK_EN to blank leading-zero digits
// (digit 0 is always shown).
// -----------------------------------------------------------------------------
module debug_scan_display
    import debug_disp_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 16,
    parameter int SCAN_PERIOD = 50_000_000
) (
    input  logic                          CLOCK_50,
    input  logic                          Reset_n,
    input  logic [NUM_CH*DATA_W-1:0]      ch_data,
    input  logic [$clog2(NUM_CH)-1:0]     sel_sw,
    input  logic                          auto_mode,
    input  logic                          step,
    input  logic                          freeze,
    output logic [$clog2(NUM_CH)-1:0]     ch_out,
    output logic [DATA_W-1:0]             value_out,
    output logic [(DATA_W/4)*7-1:0]       hex_out
);

    localparam int DIGITS = DATA_W / 4;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(SCAN_PERIOD);

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    NUM_CH_X = NUM_CH[CH_W:0];
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_PERIOD - 1);

    logic [CH_W-1:0]       ch_reg, ch_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_W-1:0]     value_reg;
    logic [DATA_W-1:0]     mux_val;
    logic [DIGITS*7-1:0]   hex_reg, hex_next, hex_rst;
    logic [CH_W-1:0]       sel_clamped;
    logic [CH_W-1:0]       ch_inc;

    // Switch codes past the last channel pin to the last channel.
    assign sel_clamped = ({1'b0, sel_sw} >= NUM_CH_X) ? LAST_CH : sel_sw;

    // Wrap explicitly: NUM_CH need not be a power of two.
    assign ch_inc = (ch_reg == LAST_CH) ? '0 : ch_reg + 1'b1;

    // Pointer / scan counter next state. The counter is parked at 0 in manual
    // mode so that entering auto mode always starts a full period. A step
    // coinciding with terminal count takes the same single advance.
    always_comb begin
        ch_next  = ch_reg;
        cnt_next = cnt_reg;
        if (!auto_mode) begin
            ch_next  = sel_clamped;
            cnt_next = '0;
        end else if (step || (cnt_reg == LAST_CNT)) begin
            ch_next  = ch_inc;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Channel mux driven by the registered pointer, so a pointer change shows
    // up on value_out/hex_out one edge later.
    always_comb begin
        mux_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_reg == CH_W'(c)) begin
                mux_val = ch_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Per-digit decode plus the reset glyph for that digit. The reset glyphs
    // match what a value of 0 would display in the same build.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        seg7_t seg;

        hex_seg7_decode u_dec (
            .nibble (mux_val[gi*4 +: 4]),
            .seg    (seg)
        );

`ifdef DEBUG_SCAN_BLANK_EN
        if (gi == 0) begin : g_lsd
            assign hex_next[6:0] = seg;
            assign hex_rst[6:0]  = SEG_ZERO;
        end else begin : g_upper
            // Blank when this nibble and everything above it are zero.
            assign hex_next[gi*7 +: 7] =
                (mux_val[DATA_W-1:gi*4] == '0) ? SEG_BLANK : seg;
            assign hex_rst[gi*7 +: 7]  = SEG_BLANK;
        end
`else
        assign hex_next[gi*7 +: 7] = seg;
        assign hex_rst[gi*7 +: 7]  = SEG_ZERO;
`endif
    end

    // Reset wins over freeze, step and mode; freeze holds every register.
    always_ff @(posedge CLOCK_50) begin
        if (!Reset_n) begin
            ch_reg    <= '0;
            cnt_reg   <= '0;
            value_reg <= '0;
            hex_reg   <= hex_rst;
        end else if (!freeze) begin
            ch_reg    <= ch_next;
            cnt_reg   <= cnt_next;
            value_reg <= mux_val;
            hex_reg   <= hex_next;
        end
    end

    assign ch_out    = ch_reg;
    assign value_out = value_reg;
    assign hex_out   = hex_reg;

endmodule
